// File: rtl/mux16_sched_pkg.sv
// Shared constants, state encoding and helpers for the 16-way round-robin mux scheduler.
package mux16_sched_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux16_rr_pick16.sv
// Rotating priority search: first set request at or after 'start', wrapping mod 16.
module rr_pick16
  import mux16_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] j;

  // Walk from the farthest offset down so the nearest match to 'start' is written last.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    found = |req;
    idx   = start;
    j     = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = start + SEL_W'(k);
      if (req[j]) idx = j;
    end
  end

endmodule

// File: rtl/mux_16x1.sv
// Plain 16:1 single-bit multiplexer used as the shared datapath.
module mux_16x1 (
  input  logic [15:0] d,
  input  logic [3:0]  sel,
  output logic        y
);

  assign y = d[sel];

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 16:1 bit mux among 16 requesters, with a burst limit.
module mux16_rr_sched
  import mux16_sched_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] d,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             y,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] burst_cnt
);

  localparam logic [SEL_W-1:0] MAX_B = SEL_W'(MAX_BURST);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] burst_q, burst_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] pick_start;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             mux_y;

  // On rotation the search starts just past the current owner, which is exactly the new pointer.
  assign pick_start = (state_q == IDLE) ? ptr_q : sel_q + 4'd1;

  rr_pick16 u_pick (
    .req   (req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    burst_d = burst_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          grant_d = onehot(pick_idx);
          valid_d = 1'b1;
          burst_d = 4'd1;
        end
      end
      GRANT: begin
        if (out_ready) begin
          if (req[sel_q] && (burst_q < MAX_B)) begin
            burst_d = burst_q + 4'd1;
          end else begin
            ptr_d = sel_q + 4'd1;
            if (pick_found) begin
              sel_d   = pick_idx;
              grant_d = onehot(pick_idx);
              burst_d = 4'd1;
            end else begin
              state_d = IDLE;
              grant_d = '0;
              valid_d = 1'b0;
              burst_d = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!reset_b) begin
      state_q <= IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      burst_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      burst_q <= burst_d;
      ptr_q   <= ptr_d;
    end
  end

  mux_16x1 u_mux (
    .d   (d),
    .sel (sel_q),
    .y   (mux_y)
  );

  assign y         = mux_y & valid_q;
  assign out_valid = valid_q;
  assign sel       = sel_q;
  assign grant     = grant_q;
  assign burst_cnt = burst_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed scoreboard bench for mux16_rr_sched; two instances cover MAX_BURST=4 and MAX_BURST=1.
module tb_mux16_rr_sched;

  logic        clock = 1'b0;
  logic        reset_b;
  logic [15:0] req, d;
  logic        out_ready;

  logic        va, ya, vb, yb;
  logic [3:0]  sa, ba, sb_sel, bb;
  logic [15:0] ga, gb;

  always #5 clock = ~clock;

  mux16_rr_sched #(.MAX_BURST(4)) dut_a (
    .clock(clock), .reset_b(reset_b), .req(req), .d(d), .out_ready(out_ready),
    .out_valid(va), .y(ya), .sel(sa), .grant(ga), .burst_cnt(ba)
  );

  mux16_rr_sched #(.MAX_BURST(1)) dut_b (
    .clock(clock), .reset_b(reset_b), .req(req), .d(d), .out_ready(out_ready),
    .out_valid(vb), .y(yb), .sel(sb_sel), .grant(gb), .burst_cnt(bb)
  );

  typedef struct {
    string      tag;
    bit         on_b;
    logic       valid;
    logic [3:0] sel;
    logic [15:0] grant;
    logic [3:0] burst;
    logic       y;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected values are taken from the bench-driven d, so y = d[sel] & valid.
  task automatic expect_out(input string tag, input bit on_b, input logic valid,
                            input logic [3:0] s, input logic [3:0] b);
    exp_t e;
    e.tag   = tag;
    e.on_b  = on_b;
    e.valid = valid;
    e.sel   = s;
    e.grant = valid ? (16'h0001 << s) : 16'h0000;
    e.burst = b;
    e.y     = valid & d[s];
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.on_b) begin
        check({e.tag, "/b.valid"}, 16'(vb), 16'(e.valid));
        check({e.tag, "/b.sel"},   16'(sb_sel), 16'(e.sel));
        check({e.tag, "/b.grant"}, gb, e.grant);
        check({e.tag, "/b.burst"}, 16'(bb), 16'(e.burst));
        check({e.tag, "/b.y"},     16'(yb), 16'(e.y));
      end else begin
        check({e.tag, "/a.valid"}, 16'(va), 16'(e.valid));
        check({e.tag, "/a.sel"},   16'(sa), 16'(e.sel));
        check({e.tag, "/a.grant"}, ga, e.grant);
        check({e.tag, "/a.burst"}, 16'(ba), 16'(e.burst));
        check({e.tag, "/a.y"},     16'(ya), 16'(e.y));
      end
    end
  endtask

  task automatic do_reset();
    reset_b   = 1'b0;
    req       = 16'h0000;
    out_ready = 1'b0;
    expect_out("rst", 1'b0, 1'b0, 4'd0, 4'd0);
    expect_out("rst", 1'b1, 1'b0, 4'd0, 4'd0);
    tick();
    reset_b = 1'b1;
  endtask

  initial begin
    // Reset held two edges with every requester asking.
    reset_b = 1'b0; req = 16'hFFFF; d = 16'hFFFF; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_out("reset", 1'b0, 1'b0, 4'd0, 4'd0);
      expect_out("reset", 1'b1, 1'b0, 4'd0, 4'd0);
      tick();
    end
    reset_b = 1'b1; req = 16'h0000;
    expect_out("idle", 1'b0, 1'b0, 4'd0, 4'd0);
    expect_out("idle", 1'b1, 1'b0, 4'd0, 4'd0);
    tick();

    // Single requester 5: bursts of 4 then re-grant with no bubble.
    req = 16'h0020; d = 16'h0020; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      expect_out("burst", 1'b0, 1'b1, 4'd5, 4'(i));
      expect_out("burst", 1'b1, 1'b1, 4'd5, 4'd1);
      tick();
    end
    expect_out("regrant", 1'b0, 1'b1, 4'd5, 4'd1);
    tick();
    expect_out("regrant2", 1'b0, 1'b1, 4'd5, 4'd2);
    tick();
    req = 16'h0000;
    expect_out("to_idle", 1'b0, 1'b0, 4'd5, 4'd0);
    tick();

    // Rotation and wrap between requesters 0 and 15.
    do_reset();
    req = 16'h8001; d = 16'h8000; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_out("rot", 1'b1, 1'b1, (i % 2 == 0) ? 4'd0 : 4'd15, 4'd1);
      expect_out("rot", 1'b0, 1'b1, (i < 4) ? 4'd0 : 4'd15, (i < 4) ? 4'(i + 1) : 4'd1);
      tick();
    end

    // Backpressure: grant to 3 held while its request drops.
    do_reset();
    req = 16'h0008; d = 16'h0008; out_ready = 1'b0;
    expect_out("bp_grant", 1'b0, 1'b1, 4'd3, 4'd1);
    tick();
    req = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      expect_out("bp_hold", 1'b0, 1'b1, 4'd3, 4'd1);
      expect_out("bp_hold", 1'b1, 1'b1, 4'd3, 4'd1);
      tick();
    end
    out_ready = 1'b1;
    expect_out("bp_done", 1'b0, 1'b0, 4'd3, 4'd0);
    expect_out("bp_done", 1'b1, 1'b0, 4'd3, 4'd0);
    tick();

    // Early rotation: requester 1 stops after two transfers, requester 2 follows.
    do_reset();
    req = 16'h0006; d = 16'h0006; out_ready = 1'b1;
    expect_out("early1", 1'b0, 1'b1, 4'd1, 4'd1);
    tick();
    expect_out("early2", 1'b0, 1'b1, 4'd1, 4'd2);
    tick();
    req = 16'h0004;
    expect_out("early_rot", 1'b0, 1'b1, 4'd2, 4'd1);
    expect_out("early_rot", 1'b1, 1'b1, 4'd2, 4'd1);
    tick();

    // Full fairness sweep with MAX_BURST=1: every index in turn, wrapping.
    do_reset();
    req = 16'hFFFF; d = 16'hA5C3; out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      expect_out("sweep", 1'b1, 1'b1, 4'(i % 16), 4'd1);
      tick();
    end

    // Reset mid-grant, then re-arbitration from pointer 0.
    do_reset();
    req = 16'h0200; d = 16'h0201; out_ready = 1'b0;
    expect_out("mid_grant", 1'b0, 1'b1, 4'd9, 4'd1);
    tick();
    reset_b = 1'b0; req = 16'h0201;
    expect_out("mid_reset", 1'b0, 1'b0, 4'd0, 4'd0);
    tick();
    reset_b = 1'b1;
    expect_out("rearb", 1'b0, 1'b1, 4'd0, 4'd1);
    expect_out("rearb", 1'b1, 1'b1, 4'd0, 4'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux16_rr_sched.md
Name: mux16_rr_sched

Overview:
- Round-robin scheduler that shares the 16:1 bit-mux datapath (mux_16x1) between 16 requesters.
- Each requester raises req[i] and presents its data bit on d[i].
- The scheduler drives the 4-bit mux select and a one-hot grant, and presents the selected bit on a valid/ready output port.
- Sits between the requesters and a single serial consumer.

Parameters:
- MAX_BURST, 4: maximum consecutive accepted transfers one requester may take before priority rotates; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock
- reset_b  in  1  synchronous active-low reset
- req  in  16  request vector; bit i = requester i wants the mux
- d  in  16  data bits; d[i] must be held stable while grant[i]=1
- out_ready  in  1  consumer accepts y this cycle
- out_valid  out  1  y holds a valid bit from the granted requester
- y  out  1  = d[sel] when out_valid=1, else 0 (through mux_16x1, gated)
- sel  out  4  registered mux select = index of granted requester
- grant  out  16  one-hot grant (all-zero when idle)
- burst_cnt  out  4  transfers accepted in the current grant, including the one in flight

Behaviour:
- Interface convention: one clock; reset is synchronous and active-low.
- Reset (reset_b=0 at a rising clock edge): state=IDLE, out_valid=0, grant=0, sel=0, burst_cnt=0, priority pointer ptr=0. Reset takes effect mid-grant with no transfer completed; y=0 the following cycle.
- States: IDLE, GRANT.
- Arbitration function pick(start): first index i with req[i]=1, searching start, start+1, ... 15, 0, ... start-1 (mod-16 wrap).
- IDLE:
  - If req≠0 at clock edge: GRANT, sel=pick(ptr), grant=1<<sel, out_valid=1, burst_cnt=1.
  - Latency req→out_valid is exactly 1 cycle.
  - If req=0: stay IDLE.
- GRANT, no transfer (out_ready=0):
  - Hold sel, grant, out_valid=1 and burst_cnt unchanged.
  - req is ignored; a requester dropping req mid-grant does not cancel the pending bit.
- GRANT, transfer (out_valid & out_ready), first match wins:
  - Continue: req[sel]=1 and burst_cnt<MAX_BURST → keep sel, burst_cnt+1, out_valid stays 1.
  - Rotate: otherwise set ptr=(sel+1) mod 16. If req≠0, regrant to pick(ptr), burst_cnt=1, out_valid stays 1 with no bubble. The old requester is eligible only if it is the sole requester (searched last).
  - Otherwise → IDLE, out_valid=0, grant=0, burst_cnt=0; sel holds its last value.
- Wrap: sel=15 rotation gives ptr=0.
- Fairness: any continuously requesting input is granted within 15 grants.
- Simultaneous req changes during the transfer cycle are sampled in that same cycle for the next decision.
- sel, grant, out_valid and burst_cnt are all registered. y is combinational from sel/d through mux_16x1, ANDed with out_valid.
- Exactly one grant bit is set whenever out_valid=1; grant=0 whenever out_valid=0.

Decomposition:
- Package mux16_sched_pkg:
  - N_REQ=16, SEL_W=4
  - state encoding IDLE=1'b0, GRANT=1'b1
- Sub-modules:
  - Existing mux_16x1 instantiated unchanged as the datapath.
  - One natural new sub-module rr_pick16 (combinational: req, start → found, idx).
- Controller FSM, pointer and burst counter stay in mux16_rr_sched.

Test Plan:
- Reset/idle: reset_b=0 for 2 cycles with req=16'hFFFF → out_valid=0, grant=0, sel=0, y=0. Release with req=0 → stays IDLE.
- Single requester burst: req=16'h0020, d=16'h0020, out_ready=1, MAX_BURST=4:
  - out_valid=1 one cycle after req, sel=5, y=1.
  - burst_cnt 1,2,3,4, then re-grant sel=5 with burst_cnt=1, no bubble.
- Rotation/wrap: req=16'h8001 held, out_ready=1, MAX_BURST=1 → grants alternate sel=0,15,0,15; ptr wraps 15→0.
- Backpressure: granted sel=3, out_ready=0 for 5 cycles while req[3] drops → out_valid, sel=3 and grant=16'h0008 all held. On out_ready=1 one transfer occurs, then IDLE (req=0) next cycle.
- Early rotation: req=16'h0006, MAX_BURST=4:
  - Requester 1 takes 2 transfers, then drops req.
  - Next grant is sel=2 on the following cycle with burst_cnt=1.
- Reset mid-grant: sel=9 with out_valid=1, assert reset_b=0 for one edge → next cycle out_valid=0, grant=0, ptr=0. With req=16'h0201 re-arbitration grants sel=0.
